// File: rtl/mood_pkg.sv
// mood_pkg -- shared definitions for the stimulus scheduler.
//   sched_state_e      : scheduler FSM encoding (IDLE=0, GRANT=1, SLEEP=2)
//   N_SRC_DEFAULT      : default number of stimulus sources
//   HOLD_TICKS_DEFAULT : default number of model ticks a grant is held
//   DROP_CNT_W         : width of the dropped-request counter
package mood_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SLEEP = 2'd2
  } sched_state_e;

  localparam int N_SRC_DEFAULT      = 7;
  localparam int HOLD_TICKS_DEFAULT = 4;
  localparam int DROP_CNT_W         = 8;

endpackage

// File: rtl/stim_scheduler_rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   pending : request vector to search
//   start   : index the search begins at (must be < N_SRC)
//   found   : high when any bit of pending is set
//   idx     : first set index at or after start, wrapping N_SRC-1 -> 0
module rr_pick
  import mood_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk the search order backwards so the earliest hit is the last one written.
  always_comb begin
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N_SRC) begin
        pos = pos - N_SRC;
      end else begin
        pos = pos;
      end
      if (pending[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/stim_scheduler.sv
// stim_scheduler -- grants one stimulus source at a time to the stress/pleasure
// regulators, holding each grant for HOLD_TICKS model ticks.
//   clk, rst   : clock and synchronous active-high reset
//   tick       : one-clk model-rate enable
//   stim_req   : level requests; rising edges are latched into pending
//   sleeping   : creature asleep; aborts/suppresses grants
//   stim_grant : registered one-hot grant, zero when idle
//   busy       : registered, high while a grant is held
//   pending    : latched request vector
//   drop_cnt   : saturating count of edges on already-pending sources
// Build option: define STIM_SCHED_DROP_CNT_EN to enable the drop counter;
// without it drop_cnt is tied to zero.
module stim_scheduler
  import mood_pkg::*;
#(
  parameter int N_SRC      = N_SRC_DEFAULT,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [N_SRC-1:0]      stim_req,
  input  logic                  sleeping,
  output logic [N_SRC-1:0]      stim_grant,
  output logic                  busy,
  output logic [N_SRC-1:0]      pending,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int              IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);
  localparam logic [3:0]      HOLD_LOAD = 4'(HOLD_TICKS - 1);

  sched_state_e     state_r, state_s;
  logic [N_SRC-1:0] stim_req_q_r, edge_s;
  logic [N_SRC-1:0] pending_r, pending_s, clear_mask_s;
  logic [N_SRC-1:0] grant_r, grant_s;
  logic             busy_r, busy_s;
  logic [3:0]       hold_r, hold_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic [IDX_W-1:0] last_grant_r, last_grant_s;
  logic [IDX_W-1:0] rr_start_s, rr_idx_s;
  logic             rr_found_s;

  function automatic logic [N_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    logic [N_SRC-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign edge_s     = stim_req & ~stim_req_q_r;
  assign rr_start_s = (last_grant_r == LAST_IDX) ? '0 : last_grant_r + IDX_W'(1);

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pending (pending_r),
    .start   (rr_start_s),
    .found   (rr_found_s),
    .idx     (rr_idx_s)
  );

  // Next-state and next-output logic; sleeping beats a coincident tick.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    busy_s       = busy_r;
    hold_s       = hold_r;
    sel_s        = sel_r;
    last_grant_s = last_grant_r;
    clear_mask_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (sleeping) begin
          state_s = ST_SLEEP;
          grant_s = '0;
          busy_s  = 1'b0;
        end else if (tick && rr_found_s) begin
          state_s = ST_GRANT;
          sel_s   = rr_idx_s;
          hold_s  = HOLD_LOAD;
          grant_s = idx_onehot(rr_idx_s);
          busy_s  = 1'b1;
        end else begin
          grant_s = '0;
          busy_s  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (sleeping) begin
          // Abort keeps the request pending and the round-robin pointer.
          state_s = ST_SLEEP;
          grant_s = '0;
          busy_s  = 1'b0;
        end else if (tick) begin
          if (hold_r == 4'd0) begin
            state_s      = ST_IDLE;
            clear_mask_s = idx_onehot(sel_r);
            last_grant_s = sel_r;
            grant_s      = '0;
            busy_s       = 1'b0;
          end else begin
            hold_s = hold_r - 4'd1;
          end
        end else begin
          hold_s = hold_r;
        end
      end
      ST_SLEEP: begin
        grant_s = '0;
        busy_s  = 1'b0;
        if (!sleeping) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SLEEP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // A new edge on the source being retired re-arms it (set wins over clear).
  assign pending_s = (pending_r & ~clear_mask_s) | edge_s;

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      stim_req_q_r <= '0;
      pending_r    <= '0;
      grant_r      <= '0;
      busy_r       <= 1'b0;
      hold_r       <= 4'd0;
      sel_r        <= '0;
      last_grant_r <= LAST_IDX;
    end else begin
      state_r      <= state_s;
      stim_req_q_r <= stim_req;
      pending_r    <= pending_s;
      grant_r      <= grant_s;
      busy_r       <= busy_s;
      hold_r       <= hold_s;
      sel_r        <= sel_s;
      last_grant_r <= last_grant_s;
    end
  end

  assign stim_grant = grant_r;
  assign busy       = busy_r;
  assign pending    = pending_r;

`ifdef STIM_SCHED_DROP_CNT_EN
  logic [N_SRC-1:0]      drop_s;
  logic [DROP_CNT_W-1:0] drop_cnt_r, drop_cnt_s;

  function automatic int count_ones(input logic [N_SRC-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N_SRC; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

  // Saturating add of this cycle's drops (several sources may drop at once).
  always_comb begin
    drop_s = edge_s & pending_r & ~clear_mask_s;
    if ((int'(drop_cnt_r) + count_ones(drop_s)) > 255) begin
      drop_cnt_s = 8'd255;
    end else begin
      drop_cnt_s = DROP_CNT_W'(int'(drop_cnt_r) + count_ones(drop_s));
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_cnt_s;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
